// File: rtl/mac_rr_scheduler.sv
// Round-robin front end sharing one 8x8 multiply / 16-bit add datapath among NREQ requesters.
// Two-stage valid/ready pipeline with an idle-driven datapath clock enable.
module mac_rr_scheduler #(
   parameter int NREQ      = 4,
   parameter int IDW       = 2,
   parameter int IDLE_GATE = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ_VALID,
   output logic [NREQ-1:0]   REQ_READY,
   input  logic [NREQ*8-1:0] REQ_A,
   input  logic [NREQ*8-1:0] REQ_B,
   input  logic [NREQ*16-1:0] REQ_C,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [IDW-1:0]    RSP_ID,
   output logic [15:0]       RSP_Y,
   output logic              RSP_COUT,
   output logic              DP_CLK_EN
);

   localparam int CNTW = $clog2(IDLE_GATE + 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_GATED  = 2'd1,
      ST_WAKE   = 2'd2
   } state_t;

   state_t            state_reg;
   logic [IDW-1:0]    ptr_reg;
   logic [CNTW-1:0]   idle_cnt_reg;
   logic              dp_en_reg;

   logic              s1_valid_reg;
   logic [IDW-1:0]    s1_id_reg;
   logic [15:0]       s1_prod_reg;
   logic [15:0]       s1_c_reg;

   logic              s2_valid_reg;
   logic [IDW-1:0]    s2_id_reg;
   logic [15:0]       s2_y_reg;
   logic              s2_cout_reg;

   logic [7:0]        a_arr [NREQ];
   logic [7:0]        b_arr [NREQ];
   logic [15:0]       c_arr [NREQ];

   logic              grant_found;
   logic [IDW-1:0]    grant_id;
   logic              s1_can_load;
   logic              accept;
   logic              s2_advance;
   logic              idle;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = REQ_A[8*gi +: 8];
         assign b_arr[gi] = REQ_B[8*gi +: 8];
         assign c_arr[gi] = REQ_C[16*gi +: 16];
      end
   endgenerate

   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NREQ)
         sum = sum - NREQ;
      return sum[IDW-1:0];
   endfunction

   // First valid requester at or above the pointer, wrapping to 0.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_found && REQ_VALID[rr_index(ptr_reg, k)]) begin
            grant_found = 1'b1;
            grant_id    = rr_index(ptr_reg, k);
         end
      end
   end

   assign s1_can_load = !s1_valid_reg || !s2_valid_reg || RSP_READY;
   assign accept      = !RST && (state_reg == ST_ACTIVE) && s1_can_load && grant_found;
   assign s2_advance  = s1_valid_reg && (!s2_valid_reg || RSP_READY);
   assign idle        = !(|REQ_VALID) && !s1_valid_reg && !s2_valid_reg;

   always_comb begin
      REQ_READY = '0;
      if (accept)
         REQ_READY[grant_id] = 1'b1;
   end

   // Control path: runs on the free-running clock.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= ST_ACTIVE;
         ptr_reg      <= '0;
         idle_cnt_reg <= '0;
         dp_en_reg    <= 1'b1;
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else begin
         if (accept)
            ptr_reg <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

         s1_valid_reg <= accept || (s1_valid_reg && !s2_advance);

         if (s2_advance)
            s2_valid_reg <= 1'b1;
         else if (RSP_READY)
            s2_valid_reg <= 1'b0;

         case (state_reg)
            ST_ACTIVE: begin
               if (!idle) begin
                  idle_cnt_reg <= '0;
               end else if (idle_cnt_reg == CNTW'(IDLE_GATE - 1)) begin
                  state_reg    <= ST_GATED;
                  idle_cnt_reg <= '0;
                  dp_en_reg    <= 1'b0;
               end else begin
                  idle_cnt_reg <= idle_cnt_reg + CNTW'(1);
               end
            end
            ST_GATED: begin
               idle_cnt_reg <= '0;
               if (|REQ_VALID) begin
                  state_reg <= ST_WAKE;
                  dp_en_reg <= 1'b1;
               end
            end
            ST_WAKE: begin
               idle_cnt_reg <= '0;
               state_reg    <= ST_ACTIVE;
            end
            default: begin
               state_reg    <= ST_ACTIVE;
               idle_cnt_reg <= '0;
               dp_en_reg    <= 1'b1;
            end
         endcase
      end
   end

   // Datapath registers: only these sit behind the clock enable.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_id_reg   <= '0;
         s1_prod_reg <= '0;
         s1_c_reg    <= '0;
         s2_id_reg   <= '0;
         s2_y_reg    <= '0;
         s2_cout_reg <= 1'b0;
      end else if (dp_en_reg) begin
         if (accept) begin
            s1_id_reg   <= grant_id;
            s1_prod_reg <= {8'd0, a_arr[grant_id]} * {8'd0, b_arr[grant_id]};
            s1_c_reg    <= c_arr[grant_id];
         end
         if (s2_advance) begin
            s2_id_reg                 <= s1_id_reg;
            {s2_cout_reg, s2_y_reg}   <= {1'b0, s1_prod_reg} + {1'b0, s1_c_reg};
         end
      end
   end

   assign RSP_VALID = s2_valid_reg;
   assign RSP_ID    = s2_id_reg;
   assign RSP_Y     = s2_y_reg;
   assign RSP_COUT  = s2_cout_reg;
   assign DP_CLK_EN = dp_en_reg;

endmodule
